// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and types for the seven-segment display scan path.
//   NUM_DIGITS  : number of multiplexed digits on the display
//   seg_t       : active-low segment vector, bit 0 = a ... bit 6 = g
//   SEG_BLANK   : all segments off
//   ANODE_OFF   : all digit enables off (active-low)
//   HEX_SEG     : hex nibble to active-low segment pattern table
package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;

  // Index is the nibble value; patterns are active-low with bit 0 = segment a.
  localparam seg_t HEX_SEG [16] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10, // 9
    7'h08, // A
    7'h03, // b
    7'h46, // C
    7'h21, // d
    7'h06, // E
    7'h0E  // F
  };

endpackage

// File: rtl/hex_to_seven_seg.sv
// hex_to_seven_seg
// Purely combinational hex nibble to active-low seven-segment decoder.
//   i_nibble : hex digit 0..F
//   o_seg    : active-low segments, bit 0 = a ... bit 6 = g
module hex_to_seven_seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/display_scanner.sv
// display_scanner
// Drives a 4-digit common-anode seven-segment display, one digit per
// clock_1KHz cycle, selected by the upstream digitCount. Takes a tear-free
// snapshot of the display inputs at every digitCount==0 edge and applies
// leading-zero suppression, per-digit blink and a global enable.
// All outputs are registered.
//   clock_1KHz  : scan clock
//   reset_n     : asynchronous active-low reset
//   digitCount  : digit index to present (0 = least significant)
//   value       : 16-bit hex value, nibble k on digit k
//   dp_in       : decimal point request per digit
//   blank_lz    : suppress leading zeros when 1
//   blink_mask  : per-digit blink enable
//   display_en  : 0 forces the display dark (live, not snapshot)
//   anode_n     : active-low digit enables
//   segments_n  : active-low segments, bit 0 = a ... bit 6 = g
//   dp_n        : active-low decimal point
//   frame_start : high while the digit-0 output of a new frame is presented
module display_scanner
  import display_pkg::*;
#(
  parameter int BLINK_HALF_PERIOD = 250
) (
  input  logic                  clock_1KHz,
  input  logic                  reset_n,
  input  logic [1:0]            digitCount,
  input  logic [15:0]           value,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  display_en,
  output logic [NUM_DIGITS-1:0] anode_n,
  output seg_t                  segments_n,
  output logic                  dp_n,
  output logic                  frame_start
);

  localparam logic [9:0] BLINK_LAST = 10'(BLINK_HALF_PERIOD - 1);

  logic [15:0]           r_value;
  logic [NUM_DIGITS-1:0] r_dp;
  logic [NUM_DIGITS-1:0] r_blink_mask;
  logic                  r_blank_lz;
  logic [9:0]            r_blink_cnt;
  logic                  r_blink_phase;

  logic                  w_new_frame;
  logic [15:0]           w_value;
  logic [NUM_DIGITS-1:0] w_dp;
  logic [NUM_DIGITS-1:0] w_blink_mask;
  logic                  w_blank_lz;
  logic [15:0]           w_shifted;
  logic                  w_lz_blank;
  logic                  w_blink_wrap;
  logic                  w_phase_next;
  seg_t                  w_dec_seg;
  logic [NUM_DIGITS-1:0] w_anode_sel;

  logic [NUM_DIGITS-1:0] w_anode_next;
  seg_t                  w_seg_next;
  logic                  w_dp_next;

  // A digit-0 edge shows the live inputs so the frame's first digit already
  // matches the snapshot that digits 1..3 will use.
  assign w_new_frame  = (digitCount == 2'd0);
  assign w_value      = w_new_frame ? value      : r_value;
  assign w_dp         = w_new_frame ? dp_in      : r_dp;
  assign w_blink_mask = w_new_frame ? blink_mask : r_blink_mask;
  assign w_blank_lz   = w_new_frame ? blank_lz   : r_blank_lz;

  // Shifting the selected nibble to the bottom also leaves exactly the
  // nibbles k..3 in the word, so a zero test gives the leading-zero condition.
  assign w_shifted  = w_value >> {digitCount, 2'b00};
  assign w_lz_blank = w_blank_lz && !w_new_frame && (w_shifted == 16'h0000);

  assign w_anode_sel = ~(4'b0001 << digitCount);

  // The output registered on this edge uses the phase that holds after it,
  // so a wrap on the same edge already affects this digit.
  assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
  assign w_phase_next = w_blink_wrap ? ~r_blink_phase : r_blink_phase;

  hex_to_seven_seg u_dec (
    .i_nibble (w_shifted[3:0]),
    .o_seg    (w_dec_seg)
  );

  always_comb begin
    w_anode_next = ANODE_OFF;
    w_seg_next   = SEG_BLANK;
    w_dp_next    = 1'b1;
    if (display_en && !(w_phase_next && w_blink_mask[digitCount])) begin
      w_anode_next = w_anode_sel;
      w_seg_next   = w_lz_blank ? SEG_BLANK : w_dec_seg;
      w_dp_next    = ~w_dp[digitCount];
    end
  end

  always_ff @(posedge clock_1KHz or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_blink_wrap) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 10'd1;
    end
  end

  always_ff @(posedge clock_1KHz or negedge reset_n) begin
    if (!reset_n) begin
      r_value      <= '0;
      r_dp         <= '0;
      r_blink_mask <= '0;
      r_blank_lz   <= 1'b0;
    end else if (w_new_frame) begin
      r_value      <= value;
      r_dp         <= dp_in;
      r_blink_mask <= blink_mask;
      r_blank_lz   <= blank_lz;
    end
  end

  always_ff @(posedge clock_1KHz or negedge reset_n) begin
    if (!reset_n) begin
      anode_n     <= ANODE_OFF;
      segments_n  <= SEG_BLANK;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      anode_n     <= w_anode_next;
      segments_n  <= w_seg_next;
      dp_n        <= w_dp_next;
      frame_start <= w_new_frame;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  localparam int HP = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  digitCount;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic        display_en;
  logic [3:0]  anode_n;
  logic [6:0]  segments_n;
  logic        dp_n;
  logic        frame_start;

  display_scanner #(.BLINK_HALF_PERIOD(HP)) dut (
    .clock_1KHz  (clk),
    .reset_n     (reset_n),
    .digitCount  (digitCount),
    .value       (value),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .blink_mask  (blink_mask),
    .display_en  (display_en),
    .anode_n     (anode_n),
    .segments_n  (segments_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: frame snapshot and edges since reset release.
  int          n_edges;
  logic [15:0] s_val;
  logic [3:0]  s_dp;
  logic        s_bl;
  logic [3:0]  s_mk;
  logic [12:0] m_exp;

  localparam logic [12:0] DARK0 = {4'hF, 7'h7F, 1'b1, 1'b0};
  localparam logic [12:0] DARK1 = {4'hF, 7'h7F, 1'b1, 1'b1};

  function automatic logic [12:0] pk(input logic [3:0] an, input logic [6:0] sg,
                                     input logic dp, input logic fs);
    return {an, sg, dp, fs};
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [12:0] actual();
    return {anode_n, segments_n, dp_n, frame_start};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
               name, act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  task automatic model_clear();
    n_edges = 0;
    s_val = '0; s_dp = '0; s_bl = 1'b0; s_mk = '0;
  endtask

  // Drive one digit slot, clock it, update the model, sample 1 unit after the edge.
  task automatic apply(input logic [1:0] dc, input logic [15:0] v, input logic [3:0] dp,
                       input logic bl, input logic [3:0] mk, input logic en);
    int d;
    logic ph;
    logic [15:0] upper;
    digitCount = dc; value = v; dp_in = dp; blank_lz = bl; blink_mask = mk; display_en = en;
    @(posedge clk);
    n_edges++;
    d = int'(dc);
    if (dc == 2'd0) begin
      s_val = v; s_dp = dp; s_bl = bl; s_mk = mk;
    end
    ph = ((n_edges / HP) % 2) == 1;
    if (!en || (ph && s_mk[d])) begin
      m_exp = {4'hF, 7'h7F, 1'b1, dc == 2'd0};
    end else begin
      upper = s_val >> (4 * d);
      m_exp[12:9] = 4'hF & ~(4'(1) << d);
      m_exp[8:2]  = (s_bl && d != 0 && upper == 16'h0) ? 7'h7F : ref_seg(upper[3:0]);
      m_exp[1]    = ~s_dp[d];
      m_exp[0]    = (dc == 2'd0);
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", actual(), DARK0);
    reset_n = 1'b1;
    model_clear();
  endtask

  typedef struct {
    logic [1:0]  dc;
    logic [15:0] v;
    logic [3:0]  dp;
    logic        bl;
    logic        en;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset_n = 1'b0; digitCount = '0; value = '0; dp_in = '0;
    blank_lz = 1'b0; blink_mask = '0; display_en = 1'b1;
    model_clear();

    // Table vectors: blink_mask stays 0 so the blink phase never matters.
    tbl.push_back('{2'd0, 16'h1234, 4'h0, 1'b0, 1'b1, pk(4'b1110, 7'h19, 1'b1, 1'b1)});
    tbl.push_back('{2'd1, 16'h1234, 4'h0, 1'b0, 1'b1, pk(4'b1101, 7'h30, 1'b1, 1'b0)});
    tbl.push_back('{2'd2, 16'h1234, 4'h0, 1'b0, 1'b1, pk(4'b1011, 7'h24, 1'b1, 1'b0)});
    tbl.push_back('{2'd3, 16'h1234, 4'h0, 1'b0, 1'b1, pk(4'b0111, 7'h79, 1'b1, 1'b0)});
    tbl.push_back('{2'd0, 16'hABCD, 4'h0, 1'b0, 1'b1, pk(4'b1110, 7'h21, 1'b1, 1'b1)});
    tbl.push_back('{2'd1, 16'h0000, 4'h0, 1'b0, 1'b1, pk(4'b1101, 7'h46, 1'b1, 1'b0)});
    tbl.push_back('{2'd2, 16'h0000, 4'h0, 1'b0, 1'b1, pk(4'b1011, 7'h03, 1'b1, 1'b0)});
    tbl.push_back('{2'd3, 16'h0000, 4'h0, 1'b0, 1'b1, pk(4'b0111, 7'h08, 1'b1, 1'b0)});
    tbl.push_back('{2'd0, 16'h0000, 4'h0, 1'b0, 1'b1, pk(4'b1110, 7'h40, 1'b1, 1'b1)});
    tbl.push_back('{2'd0, 16'h0050, 4'h8, 1'b1, 1'b1, pk(4'b1110, 7'h40, 1'b1, 1'b1)});
    tbl.push_back('{2'd1, 16'h0050, 4'h8, 1'b1, 1'b1, pk(4'b1101, 7'h12, 1'b1, 1'b0)});
    tbl.push_back('{2'd2, 16'h0050, 4'h8, 1'b1, 1'b1, pk(4'b1011, 7'h7F, 1'b1, 1'b0)});
    tbl.push_back('{2'd3, 16'h0050, 4'h8, 1'b1, 1'b1, pk(4'b0111, 7'h7F, 1'b0, 1'b0)});
    tbl.push_back('{2'd0, 16'h0000, 4'h0, 1'b1, 1'b1, pk(4'b1110, 7'h40, 1'b1, 1'b1)});
    tbl.push_back('{2'd1, 16'h0000, 4'h0, 1'b1, 1'b1, pk(4'b1101, 7'h7F, 1'b1, 1'b0)});
    tbl.push_back('{2'd2, 16'h0000, 4'h0, 1'b1, 1'b1, pk(4'b1011, 7'h7F, 1'b1, 1'b0)});
    tbl.push_back('{2'd3, 16'h0000, 4'h0, 1'b1, 1'b1, pk(4'b0111, 7'h7F, 1'b1, 1'b0)});
    tbl.push_back('{2'd0, 16'h1111, 4'h0, 1'b0, 1'b1, pk(4'b1110, 7'h79, 1'b1, 1'b1)});
    tbl.push_back('{2'd1, 16'h2222, 4'h0, 1'b0, 1'b1, pk(4'b1101, 7'h79, 1'b1, 1'b0)});
    tbl.push_back('{2'd0, 16'h3333, 4'h0, 1'b0, 1'b1, pk(4'b1110, 7'h30, 1'b1, 1'b1)});
    tbl.push_back('{2'd1, 16'h0000, 4'h0, 1'b0, 1'b1, pk(4'b1101, 7'h30, 1'b1, 1'b0)});
    tbl.push_back('{2'd2, 16'h0000, 4'h0, 1'b0, 1'b0, DARK0});
    tbl.push_back('{2'd0, 16'h0000, 4'h0, 1'b0, 1'b0, DARK1});
    tbl.push_back('{2'd1, 16'h0000, 4'h0, 1'b0, 1'b1, pk(4'b1101, 7'h40, 1'b1, 1'b0)});

    #2;
    do_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].dc, tbl[i].v, tbl[i].dp, tbl[i].bl, 4'h0, tbl[i].en);
      check($sformatf("table[%0d]", i), actual(), tbl[i].exp);
    end

    // Blink with digit 0 masked; dc = n%4 puts digit 0 on the wrap edges.
    // Display disabled on edges 13-14 to show the phase keeps running.
    do_reset();
    for (int n = 1; n <= 21; n++) begin
      apply(2'(n % 4), 16'h8888, 4'h0, 1'b0, 4'b0001, !(n == 13 || n == 14));
      check($sformatf("blink_model[%0d]", n), actual(), m_exp);
      case (n)
        4, 12, 20: check($sformatf("blink_dark[%0d]", n), actual(), DARK1);
        8, 16:     check($sformatf("blink_lit[%0d]", n), actual(), pk(4'b1110, 7'h00, 1'b1, 1'b1));
        13:        check("enable_off", actual(), DARK0);
        15:        check("enable_back", actual(), pk(4'b0111, 7'h00, 1'b1, 1'b0));
        21:        check("blink_other", actual(), pk(4'b1101, 7'h00, 1'b1, 1'b0));
        default: ;
      endcase
    end

    // Asynchronous reset mid-frame goes dark without a clock edge.
    reset_n = 1'b0;
    #1;
    check("async_reset", actual(), DARK0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    apply(2'd2, 16'hFFFF, 4'hF, 1'b0, 4'h0, 1'b1);
    check("post_reset_no_snapshot", actual(), pk(4'b1011, 7'h40, 1'b1, 1'b0));
    apply(2'd0, 16'hFFFF, 4'hF, 1'b0, 4'h0, 1'b1);
    check("post_reset_first_frame", actual(), pk(4'b1110, 7'h0E, 1'b0, 1'b1));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      apply(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom), 1'($urandom),
            4'($urandom), $urandom_range(0, 7) != 0);
      check($sformatf("random[%0d]", k), actual(), m_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
